mos6502s_alu_mc: RTL and testbench
==================================

// Module: mos6502s_alu_mc
// PURPOSE
//  Multi-cycle, width-parametrised successor to the combinational 6502 ALU. Same op encoding and
//  flag semantics, generalised to 4*NIBBLES bits. Decimal ADC/SBC is computed one BCD digit per
//  cycle with a rippled carry; all other ops take one cycle. Operands enter and results leave over
//  valid/ready handshakes. Sits between the mos6502s sequencer and the accumulator/flag registers.
// PARAMETERS
//  NIBBLES  2  BCD digit count; datapath width W = 4*NIBBLES; legal range 2..8
// PORTS
//  clk        in   1    rising-edge clock (the only clock)
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    operand bundle valid
//  in_ready   out  1    ALU idle, bundle accepted on in_valid&&in_ready
//  a          in   W    operand A (accumulator side)
//  b          in   W    operand B (memory side)
//  c_in       in   1    carry in
//  d_flag     in   1    decimal mode; affects ADC/SBC only
//  op         in   4    0 ADC,1 SBC,2 AND,3 ORA,4 EOR,5 ASL,6 LSR,7 ROL,8 ROR,9 INC,A DEC,B CMP,C BIT,D TST,F NOP
//  out_valid  out  1    result/flags valid
//  out_ready  in   1    consumer takes result on out_valid&&out_ready
//  result     out  W    registered result
//  n,z,c,v    out  1    registered flags
//  busy       out  1    high in CALC state
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; result, n, z, c, v, out_valid, busy = 0; in_ready = 1.
//  - FSM: IDLE -accept-> CALC -last step-> DONE -out_ready-> IDLE. in_ready = (state==IDLE).
//    No overlap: a new bundle is never accepted before the previous result is taken.
//  - Operands, c_in, d_flag and op are latched on accept. Input changes afterwards are ignored.
//  - Latency from accept edge to out_valid=1: NIBBLES edges for decimal ADC/SBC, 1 edge otherwise.
//  - Decimal ADC: digit i: s=a_i+b_i+k (k0=c_in). If s>9: digit=(s+6) mod 16 and k=1. Otherwise
//    digit=s and k=0. c = final k.
//  - Decimal SBC: digit i: d=a_i-b_i-br (br0=~c_in), 5-bit. br=d[4]. Digit=br?(d+10) mod 16:d. c=~final br.
//  - Digits are processed LSB first, one per cycle. Invalid BCD inputs (digit>9) are not checked and follow
//    the formulas mod 16.
//  - Binary ADC: {c,result}=a+b+c_in. Binary SBC: {c,result}=a+~b+c_in (W+1 bits).
//  - ADC/SBC in both modes: n=result[W-1], z=(result==0).
//    ADC: v=(a[W-1]==b[W-1])&&(result[W-1]!=a[W-1]). SBC: v=(a[W-1]!=b[W-1])&&(result[W-1]!=a[W-1]).
//  - Logic/shift/inc/dec ops: W-bit forms of the 6502 ops.
//    ASL/ROL: c=a[W-1]. LSR/ROR: c=a[0]. LSR: n=0. INC/DEC wrap mod 2^W.
//    Flags an op does not define are 0.
//  - CMP: result=a-b mod 2^W, c=(a>=b), z=(a==b), n=result[W-1].
//    BIT: result=a, n=b[W-1], v=b[W-2], z=((a&b)==0).
//    TST: result=a, n and z from a. NOP: result=a, c=c_in, others 0. Op 0xE: result=a, all flags 0.
//  - DONE holds result, flags and out_valid stable until out_ready. out_ready is ignored when out_valid=0.
//  - Reset asserted mid-CALC or in DONE aborts the operation. No result is emitted.
// STRUCTURE
//  - Package mos6502s_alu_pkg: OP_* localparams (4-bit op codes), state encoding (IDLE/CALC/DONE),
//    BCD constants (limit 9, add-adjust 6, sub-adjust 10).
//  - Sub-module mos6502s_bcd_digit: combinational 1-digit add/sub with adjust.
//    Inputs: a_i, b_i, carry/borrow in, sub. Outputs: digit, carry/borrow out. Instantiated once and
//    reused per cycle via a digit-index counter (ceil(log2(NIBBLES)) bits).
//  - Result is built in a shift register. Carry/borrow, digit index and latched op live in the top level.
// TESTING
//  1. NIBBLES=2, decimal ADC a=0x58 b=0x46 c_in=1 -> result 0x05, c=1, z=0; out_valid 2 edges after accept.
//  2. NIBBLES=4, decimal ADC 0x9999+0x0001 c_in=0 -> result 0x0000, c=1, z=1, n=0; latency 4 edges.
//  3. NIBBLES=4, decimal SBC 0x1000-0x0001 c_in=1 -> result 0x0999, c=1, n=0.
//  4. NIBBLES=2, binary ADC 0x7F+0x01 c_in=0 -> 0x80, n=1, v=1, c=0; latency 1 edge.
//     Also CMP 0x10 vs 0x20 -> c=0, z=0, n=1.
//  5. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and flags unchanged,
//     in_ready=0, a second in_valid is not accepted. out_ready=1 -> IDLE next edge.
//  6. Assert rst_n=0 in mid-CALC of a NIBBLES=4 decimal op -> outputs immediately 0, in_ready=1.
//     A new op after release completes correctly.

Source files
------------

// File: rtl/mos6502s_alu_pkg.sv
// Shared op codes, FSM state encoding and BCD constants for the multi-cycle 6502 ALU.
package mos6502s_alu_pkg;

  localparam logic [3:0] OP_ADC = 4'h0;
  localparam logic [3:0] OP_SBC = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_ORA = 4'h3;
  localparam logic [3:0] OP_EOR = 4'h4;
  localparam logic [3:0] OP_ASL = 4'h5;
  localparam logic [3:0] OP_LSR = 4'h6;
  localparam logic [3:0] OP_ROL = 4'h7;
  localparam logic [3:0] OP_ROR = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_DEC = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_BIT = 4'hC;
  localparam logic [3:0] OP_TST = 4'hD;
  localparam logic [3:0] OP_RSV = 4'hE;
  localparam logic [3:0] OP_NOP = 4'hF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } alu_state_e;

  // Digit sums above this get the add-adjust; negative digit differences get the sub-adjust.
  localparam logic [4:0] BCD_LIMIT   = 5'd9;
  localparam logic [3:0] BCD_ADD_ADJ = 4'd6;
  localparam logic [3:0] BCD_SUB_ADJ = 4'd10;

endpackage

// File: rtl/mos6502s_alu_mc_if.sv
// Operand/result handshake bundle between the sequencer (master) and the ALU (slave).
interface mos6502s_alu_mc_if #(
  parameter int unsigned NIBBLES = 2
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         d_flag;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         n;
  logic         z;
  logic         c;
  logic         v;
  logic         busy;

  modport master (
    output in_valid, a, b, c_in, d_flag, op, out_ready,
    input  in_ready, out_valid, result, n, z, c, v, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, d_flag, op, out_ready,
    output in_ready, out_valid, result, n, z, c, v, busy
  );

endinterface

// File: rtl/mos6502s_bcd_digit.sv
// One BCD digit of decimal add or subtract, with decimal adjust and carry/borrow out.
module mos6502s_bcd_digit
  import mos6502s_alu_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       k_i,     // carry in (add) or borrow in (sub)
  input  logic       sub_i,
  output logic [3:0] digit_o,
  output logic       k_o      // carry out (add) or borrow out (sub)
);

  logic [4:0] sum;
  logic [4:0] diff;

  // Digit arithmetic is mod 16 so invalid BCD inputs just follow the same formulas.
  always_comb begin
    sum  = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, k_i};
    diff = {1'b0, a_i} - {1'b0, b_i} - {4'b0000, k_i};
    if (sub_i) begin
      k_o     = diff[4];
      digit_o = diff[4] ? (diff[3:0] + BCD_SUB_ADJ) : diff[3:0];
    end else begin
      k_o     = (sum > BCD_LIMIT);
      digit_o = (sum > BCD_LIMIT) ? (sum[3:0] + BCD_ADD_ADJ) : sum[3:0];
    end
  end

endmodule

// File: rtl/mos6502s_alu_mc.sv
// Multi-cycle 6502 ALU: decimal ADC/SBC ripple one digit per cycle, everything else is one step.
module mos6502s_alu_mc
  import mos6502s_alu_pkg::*;
#(
  parameter int unsigned NIBBLES = 2
) (
  input logic                clk,
  input logic                rst_n,
  mos6502s_alu_mc_if.slave   bus
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NIBBLES - 1);

  alu_state_e   state_q;
  logic [W-1:0] a_q, b_q, acc_q, result_q;
  logic [3:0]   op_q;
  logic         cin_q, dec_q, k_q;
  logic [IW-1:0] idx_q;
  logic         n_q, z_q, c_q, v_q;
  logic         in_ready_q, out_valid_q, busy_q;

  logic [3:0]   a_dig, b_dig, dig;
  logic         k_next, sub_op;
  logic [W:0]   sum_w;
  logic [W-1:0] calc_res;
  logic         calc_n, calc_z, calc_c, calc_v;

  assign sub_op = (op_q == OP_SBC);
  assign a_dig  = a_q[{idx_q, 2'b00} +: 4];
  assign b_dig  = b_q[{idx_q, 2'b00} +: 4];

  mos6502s_bcd_digit u_digit (
    .a_i     (a_dig),
    .b_i     (b_dig),
    .k_i     (k_q),
    .sub_i   (sub_op),
    .digit_o (dig),
    .k_o     (k_next)
  );

  // Final result and flags for the current op; decimal form is only used on the last digit step.
  always_comb begin
    sum_w    = '0;
    calc_res = a_q;
    calc_n   = 1'b0;
    calc_z   = 1'b0;
    calc_c   = 1'b0;
    calc_v   = 1'b0;
    case (op_q)
      OP_ADC: begin
        sum_w    = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_q};
        calc_res = sum_w[W-1:0];
        calc_c   = sum_w[W];
      end
      OP_SBC: begin
        sum_w    = {1'b0, a_q} + {1'b0, ~b_q} + {{W{1'b0}}, cin_q};
        calc_res = sum_w[W-1:0];
        calc_c   = sum_w[W];
      end
      OP_AND: calc_res = a_q & b_q;
      OP_ORA: calc_res = a_q | b_q;
      OP_EOR: calc_res = a_q ^ b_q;
      OP_ASL: begin
        calc_res = {a_q[W-2:0], 1'b0};
        calc_c   = a_q[W-1];
      end
      OP_LSR: begin
        calc_res = {1'b0, a_q[W-1:1]};
        calc_c   = a_q[0];
      end
      OP_ROL: begin
        calc_res = {a_q[W-2:0], cin_q};
        calc_c   = a_q[W-1];
      end
      OP_ROR: begin
        calc_res = {cin_q, a_q[W-1:1]};
        calc_c   = a_q[0];
      end
      OP_INC: calc_res = a_q + 1'b1;
      OP_DEC: calc_res = a_q - 1'b1;
      OP_CMP: begin
        calc_res = a_q - b_q;
        calc_c   = (a_q >= b_q);
      end
      OP_BIT: begin
        calc_n = b_q[W-1];
        calc_v = b_q[W-2];
        calc_z = ((a_q & b_q) == '0);
      end
      OP_NOP: calc_c = cin_q;
      default: calc_res = a_q;
    endcase
    if (dec_q) begin
      calc_res = {dig, acc_q[W-1:4]};
      calc_c   = sub_op ? ~k_next : k_next;
    end
    if (op_q != OP_BIT && op_q != OP_NOP && op_q != OP_RSV) begin
      calc_n = calc_res[W-1];
      calc_z = (calc_res == '0);
    end
    if (op_q == OP_ADC) begin
      calc_v = (a_q[W-1] == b_q[W-1]) && (calc_res[W-1] != a_q[W-1]);
    end else if (op_q == OP_SBC) begin
      calc_v = (a_q[W-1] != b_q[W-1]) && (calc_res[W-1] != a_q[W-1]);
    end
  end

  // Control FSM with registered handshake outputs, operand latch and digit shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      op_q        <= OP_NOP;
      cin_q       <= 1'b0;
      dec_q       <= 1'b0;
      k_q         <= 1'b0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            op_q       <= bus.op;
            cin_q      <= bus.c_in;
            dec_q      <= bus.d_flag && (bus.op == OP_ADC || bus.op == OP_SBC);
            // Subtract ripples a borrow, which is the inverse of the 6502 carry.
            k_q        <= (bus.op == OP_SBC) ? ~bus.c_in : bus.c_in;
            idx_q      <= '0;
            acc_q      <= '0;
            state_q    <= StCalc;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StCalc: begin
          if (dec_q && (idx_q != LastIdx)) begin
            acc_q <= {dig, acc_q[W-1:4]};
            k_q   <= k_next;
            idx_q <= idx_q + 1'b1;
          end else begin
            result_q    <= calc_res;
            n_q         <= calc_n;
            z_q         <= calc_z;
            c_q         <= calc_c;
            v_q         <= calc_v;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
  assign bus.n         = n_q;
  assign bus.z         = z_q;
  assign bus.c         = c_q;
  assign bus.v         = v_q;

endmodule

// File: tb/tb_mos6502s_alu_mc.sv
// Scoreboard bench for the multi-cycle ALU at NIBBLES=2 and NIBBLES=4.
module tb_mos6502s_alu_mc;
  import mos6502s_alu_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic        n, z, c, v;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        in_valid, c_in, d_flag, out_ready;
  logic [15:0] a, b;
  logic [3:0]  op;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  string sb_tag[$];

  mos6502s_alu_mc_if #(.NIBBLES(2)) bus2 ();
  mos6502s_alu_mc_if #(.NIBBLES(4)) bus4 ();

  assign bus2.in_valid  = in_valid & ~sel;
  assign bus2.a         = a[7:0];
  assign bus2.b         = b[7:0];
  assign bus2.c_in      = c_in;
  assign bus2.d_flag    = d_flag;
  assign bus2.op        = op;
  assign bus2.out_ready = out_ready;
  assign bus4.in_valid  = in_valid & sel;
  assign bus4.a         = a;
  assign bus4.b         = b;
  assign bus4.c_in      = c_in;
  assign bus4.d_flag    = d_flag;
  assign bus4.op        = op;
  assign bus4.out_ready = out_ready;

  mos6502s_alu_mc #(.NIBBLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  mos6502s_alu_mc #(.NIBBLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  logic        m_in_ready, m_out_valid, m_busy;
  logic [15:0] m_result;
  logic [3:0]  m_flags;
  assign m_in_ready  = sel ? bus4.in_ready : bus2.in_ready;
  assign m_out_valid = sel ? bus4.out_valid : bus2.out_valid;
  assign m_busy      = sel ? bus4.busy : bus2.busy;
  assign m_result    = sel ? bus4.result : {8'h00, bus2.result};
  assign m_flags     = sel ? {bus4.n, bus4.z, bus4.c, bus4.v} : {bus2.n, bus2.z, bus2.c, bus2.v};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference behaviour written straight from the op definitions.
  function automatic exp_t model(input int nib, input logic [3:0] o, input logic [15:0] ai,
                                 input logic [15:0] bi, input logic ci, input logic di);
    exp_t e;
    int w, mask, av, bv, t, k, s, dg, res, am, bm, rm;
    w = 4 * nib;
    mask = (1 << w) - 1;
    av = int'(ai) & mask;
    bv = int'(bi) & mask;
    e.n = 0; e.z = 0; e.c = 0; e.v = 0; e.lat = 1; e.acc = 0;
    res = av;
    if ((o == OP_ADC || o == OP_SBC) && di) begin
      e.lat = nib;
      k = (o == OP_SBC) ? int'(!ci) : int'(ci);
      res = 0;
      for (int i = 0; i < nib; i++) begin
        s = (o == OP_ADC) ? ((av >> (4 * i)) & 15) + ((bv >> (4 * i)) & 15) + k
                          : ((av >> (4 * i)) & 15) - ((bv >> (4 * i)) & 15) - k;
        if (o == OP_ADC) begin
          if (s > 9) begin dg = (s + 6) % 16; k = 1; end
          else begin dg = s; k = 0; end
        end else begin
          if (s < 0) begin dg = (s + 26) % 16; k = 1; end
          else begin dg = s; k = 0; end
        end
        res = res | (dg << (4 * i));
      end
      e.c = (o == OP_ADC) ? (k != 0) : (k == 0);
    end else begin
      case (o)
        OP_ADC: begin t = av + bv + int'(ci); res = t & mask; e.c = ((t >> w) & 1) != 0; end
        OP_SBC: begin
          t = av + ((~bv) & mask) + int'(ci); res = t & mask; e.c = ((t >> w) & 1) != 0;
        end
        OP_AND: res = av & bv;
        OP_ORA: res = av | bv;
        OP_EOR: res = av ^ bv;
        OP_ASL: begin res = (av << 1) & mask; e.c = ((av >> (w - 1)) & 1) != 0; end
        OP_LSR: begin res = av >> 1; e.c = (av & 1) != 0; end
        OP_ROL: begin res = ((av << 1) | int'(ci)) & mask; e.c = ((av >> (w - 1)) & 1) != 0; end
        OP_ROR: begin res = (av >> 1) | (int'(ci) << (w - 1)); e.c = (av & 1) != 0; end
        OP_INC: res = (av + 1) & mask;
        OP_DEC: res = (av - 1) & mask;
        OP_CMP: begin res = (av - bv) & mask; e.c = (av >= bv); end
        OP_NOP: e.c = ci;
        default: res = av;
      endcase
    end
    if (o == OP_BIT) begin
      e.n = ((bv >> (w - 1)) & 1) != 0;
      e.v = ((bv >> (w - 2)) & 1) != 0;
      e.z = (av & bv) == 0;
    end else if (o != OP_NOP && o != OP_RSV) begin
      e.n = ((res >> (w - 1)) & 1) != 0;
      e.z = (res == 0);
    end
    am = (av >> (w - 1)) & 1;
    bm = (bv >> (w - 1)) & 1;
    rm = (res >> (w - 1)) & 1;
    if (o == OP_ADC) e.v = (am == bm) && (rm != am);
    if (o == OP_SBC) e.v = (am != bm) && (rm != am);
    e.res = 16'(res);
    return e;
  endfunction

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain.pending", sb.size(), 0);
      sb.delete();
      sb_tag.delete();
    end
  endtask

  task automatic send(input logic s, input logic [3:0] o, input logic [15:0] aa,
                      input logic [15:0] bb, input logic ci, input logic dd,
                      input string tag, input bit push);
    exp_t e;
    int n = 0;
    if (s != sel) drain();
    @(posedge clk);
    #1;
    sel = s; op = o; a = aa; b = bb; c_in = ci; d_flag = dd; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!m_in_ready && n < 50);
    if (!m_in_ready) begin
      check({tag, ".accept"}, m_in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    e = model(s ? 4 : 2, o, aa, bb, ci, dd);
    e.acc = cyc + 1;
    if (push) begin
      sb.push_back(e);
      sb_tag.push_back(tag);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Output monitor: pops the scoreboard whenever the consumer takes a result.
  initial begin
    logic prev_ov = 1'b0;
    int   rise_cyc = 0;
    exp_t e;
    string t;
    forever begin
      @(negedge clk);
      if (m_out_valid && !prev_ov) rise_cyc = cyc;
      prev_ov = m_out_valid;
      if (rst_n && m_out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb.unexpected_out", m_out_valid, 0);
        end else begin
          e = sb.pop_front();
          t = sb_tag.pop_front();
          check({t, ".result"}, m_result, e.res);
          check({t, ".nzcv"}, m_flags, {e.n, e.z, e.c, e.v});
          check({t, ".latency"}, rise_cyc - e.acc, e.lat);
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; d_flag = 1'b0; op = OP_NOP;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("rst.result", m_result, 0);
      check("rst.nzcv", m_flags, 0);
      check("rst.out_valid", m_out_valid, 0);
      check("rst.busy", m_busy, 0);
      check("rst.in_ready", m_in_ready, 1);
    end
    sel = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(0, OP_ADC, 16'h0058, 16'h0046, 1, 1, "dec_adc8", 1);
    send(0, OP_ADC, 16'h007F, 16'h0001, 0, 0, "bin_adc8", 1);
    send(0, OP_CMP, 16'h0010, 16'h0020, 0, 0, "cmp8", 1);
    send(0, OP_BIT, 16'h0001, 16'h00C2, 0, 0, "bit8", 1);
    send(0, OP_SBC, 16'h0000, 16'h0001, 1, 1, "dec_sbc8", 1);
    send(1, OP_ADC, 16'h9999, 16'h0001, 0, 1, "dec_adc16", 1);
    send(1, OP_SBC, 16'h1000, 16'h0001, 1, 1, "dec_sbc16", 1);
    send(1, OP_ROR, 16'h8001, 16'h0000, 1, 0, "ror16", 1);

    for (int i = 0; i < 40; i++) begin
      send(1'(i % 2), 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), "rnd", 1);
    end
    drain();

    // Backpressure: result must stay put and a second bundle must not be taken.
    out_ready = 1'b0;
    send(0, OP_ADC, 16'h007F, 16'h0001, 0, 0, "bp", 1);
    n = 0;
    while (!m_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp.out_valid", m_out_valid, 1);
    @(posedge clk);
    #1;
    a = 16'h0011; b = 16'h0022; op = OP_EOR; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.hold_result", m_result, 16'h0080);
      check("bp.hold_nzcv", m_flags, 4'b1001);
      check("bp.in_ready", m_in_ready, 0);
      check("bp.hold_valid", m_out_valid, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.idle_in_ready", m_in_ready, 1);
    check("bp.idle_out_valid", m_out_valid, 0);
    @(posedge clk);
    #1;
    check("bp.no_second", m_out_valid, 0);
    drain();

    // Reset in the middle of a 4-digit decimal op aborts it.
    send(1, OP_ADC, 16'h9999, 16'h0001, 0, 1, "abort", 0);
    @(posedge clk);
    #1;
    check("abort.busy_before", m_busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort.result", m_result, 0);
    check("abort.nzcv", m_flags, 0);
    check("abort.out_valid", m_out_valid, 0);
    check("abort.busy", m_busy, 0);
    check("abort.in_ready", m_in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(1, OP_SBC, 16'h0250, 16'h0075, 1, 1, "post_abort", 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
